// File: rtl/sz_pkg.sv
// Elaboration-time helpers shared by the pipelined selector tree: tree sizing
// and parameter legality.
package sz_pkg;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    // Number of registered levels needed so that radix**levels >= num_in.
    function automatic int tree_levels(input int num_in, input int radix);
        int levels;
        int cap;
        levels = 1;
        cap = radix;
        while (cap < num_in) begin
            cap = cap * radix;
            levels++;
        end
        return levels;
    endfunction

    // Word count presented to level k (k=0 sees the raw inputs).
    function automatic int level_count(input int num_in, input int radix, input int k);
        int n;
        n = num_in;
        for (int i = 0; i < k; i++) n = (n + radix - 1) / radix;
        return n;
    endfunction

    function automatic bit radix_legal(input int radix);
        return (radix == 2) || (radix == 4) || (radix == 8);
    endfunction

endpackage

// File: rtl/mux_tree_stage.sv
// One registered level of the selector tree: ceil(N_IN/RADIX) RADIX:1 nodes,
// carrying the unconsumed select bits, valid and err beside the data.
module mux_tree_stage
    import sz_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int N_IN     = 4,
    parameter int RADIX    = 4,
    parameter int SEL_IN_W = 2,
    localparam int RB        = clog2(RADIX),
    localparam int N_OUT     = (N_IN + RADIX - 1) / RADIX,
    localparam int SEL_OUT_W = (SEL_IN_W > RB) ? SEL_IN_W - RB : 1
) (
    input  logic                   clock,
    input  logic                   aclr,
    input  logic                   adv,
    input  logic                   in_valid,
    input  logic                   in_err,
    input  logic [SEL_IN_W-1:0]    in_sel,
    input  logic [N_IN*WIDTH-1:0]  in_data,
    output logic                   out_valid,
    output logic                   out_err,
    output logic [SEL_OUT_W-1:0]   out_sel,
    output logic [N_OUT*WIDTH-1:0] out_data
);

    logic [WIDTH-1:0]       pad [N_OUT][RADIX];
    logic [N_OUT*WIDTH-1:0] pick;
    logic [RB-1:0]          node_sel;
    logic [SEL_OUT_W-1:0]   sel_rest;

    assign node_sel = in_sel[RB-1:0];

    if (SEL_IN_W > RB) begin : g_rest
        assign sel_rest = in_sel[SEL_IN_W-1:RB];
    end else begin : g_last
        assign sel_rest = '0;
    end

    // Missing node inputs are zero words so an aliased select can never leak data.
    always_comb begin
        for (int j = 0; j < N_OUT; j++)
            for (int r = 0; r < RADIX; r++)
                pad[j][r] = '0;
        for (int i = 0; i < N_IN; i++)
            pad[i / RADIX][i % RADIX] = in_data[i*WIDTH +: WIDTH];
        pick = '0;
        for (int j = 0; j < N_OUT; j++)
            pick[j*WIDTH +: WIDTH] = pad[j][node_sel];
    end

    // stage register
    always_ff @(posedge clock) begin
        if (aclr) begin
            out_valid <= 1'b0;
            out_err   <= 1'b0;
            out_sel   <= '0;
            out_data  <= '0;
        end else if (adv) begin
            out_valid <= in_valid;
            out_err   <= in_err;
            out_sel   <= sel_rest;
            out_data  <= in_err ? '0 : pick;
        end
    end

endmodule

// File: rtl/pipe_mux_tree.sv
// Fully pipelined N:1 word selector: a chain of registered radix-R levels under
// one global stall, with out-of-range select detection.
module pipe_mux_tree
    import sz_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 64,
    parameter int RADIX  = 4,
    localparam int SEL_W = clog2(NUM_IN)
) (
    input  logic                    clock,
    input  logic                    aclr,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        in_sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_err,
    output logic                    out_valid,
    input  logic                    out_ready
);

    localparam int RB     = clog2(RADIX);
    localparam int LEVELS = tree_levels(NUM_IN, RADIX);
    localparam int TW     = RB * LEVELS;

    if (!radix_legal(RADIX)) begin : g_bad_radix
        $error("pipe_mux_tree: RADIX must be 2, 4 or 8");
    end

    logic adv;
    logic unused_sel;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
        localparam int NI = level_count(NUM_IN, RADIX, k);
        localparam int NO = level_count(NUM_IN, RADIX, k + 1);
        localparam int SI = TW - RB * k;
        localparam int SO = (SI > RB) ? SI - RB : 1;

        logic [NI*WIDTH-1:0] d_in;
        logic [SI-1:0]       s_in;
        logic                v_in;
        logic                e_in;
        logic [NO*WIDTH-1:0] d_out;
        logic [SO-1:0]       s_out;
        logic                v_out;
        logic                e_out;

        // Error is decided once at acceptance; the select is zero-extended to the full tree depth.
        if (k == 0) begin : g_head
            assign d_in = in_data;
            assign s_in = TW'(in_sel);
            assign v_in = in_valid;
            assign e_in = in_valid && ({1'b0, in_sel} >= (SEL_W + 1)'(NUM_IN));
        end else begin : g_link
            assign d_in = g_lvl[k-1].d_out;
            assign s_in = g_lvl[k-1].s_out;
            assign v_in = g_lvl[k-1].v_out;
            assign e_in = g_lvl[k-1].e_out;
        end

        mux_tree_stage #(
            .WIDTH    (WIDTH),
            .N_IN     (NI),
            .RADIX    (RADIX),
            .SEL_IN_W (SI)
        ) u_stage (
            .clock     (clock),
            .aclr      (aclr),
            .adv       (adv),
            .in_valid  (v_in),
            .in_err    (e_in),
            .in_sel    (s_in),
            .in_data   (d_in),
            .out_valid (v_out),
            .out_err   (e_out),
            .out_sel   (s_out),
            .out_data  (d_out)
        );
    end

    assign out_data   = g_lvl[LEVELS-1].d_out;
    assign out_err    = g_lvl[LEVELS-1].e_out;
    assign out_valid  = g_lvl[LEVELS-1].v_out;
    assign unused_sel = ^g_lvl[LEVELS-1].s_out;

endmodule

// File: tb/tb_pipe_mux_tree.sv
// Directed bench for pipe_mux_tree: a 64/4 stream instance plus 45/4, 8/2 and
// 64/8 instances probed from a vector table.
module tb_pipe_mux_tree;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic aclr;
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;

    // main instance: 64 inputs, radix 4
    logic [64*32-1:0] in_data;
    logic [5:0]       in_sel;
    logic             in_valid, in_ready;
    logic [31:0]      out_data;
    logic             out_err, out_valid, out_ready;

    pipe_mux_tree #(.WIDTH(32), .NUM_IN(64), .RADIX(4)) dut (
        .clock(clk), .aclr(aclr), .in_data(in_data), .in_sel(in_sel),
        .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
        .out_err(out_err), .out_valid(out_valid), .out_ready(out_ready)
    );

    // 45 inputs, radix 4
    logic [45*32-1:0] d45;
    logic [5:0]       s45;
    logic             v45, r45, e45, ov45;
    logic [31:0]      o45;

    pipe_mux_tree #(.WIDTH(32), .NUM_IN(45), .RADIX(4)) dut45 (
        .clock(clk), .aclr(aclr), .in_data(d45), .in_sel(s45),
        .in_valid(v45), .in_ready(r45), .out_data(o45),
        .out_err(e45), .out_valid(ov45), .out_ready(1'b1)
    );

    // 8 inputs, radix 2, 8-bit words
    logic [8*8-1:0] d2;
    logic [2:0]     s2;
    logic           v2, r2, e2, ov2;
    logic [7:0]     o2;

    pipe_mux_tree #(.WIDTH(8), .NUM_IN(8), .RADIX(2)) dut2 (
        .clock(clk), .aclr(aclr), .in_data(d2), .in_sel(s2),
        .in_valid(v2), .in_ready(r2), .out_data(o2),
        .out_err(e2), .out_valid(ov2), .out_ready(1'b1)
    );

    // 64 inputs, radix 8
    logic [64*32-1:0] d8;
    logic [5:0]       s8;
    logic             v8, r8, e8, ov8;
    logic [31:0]      o8;

    pipe_mux_tree #(.WIDTH(32), .NUM_IN(64), .RADIX(8)) dut8 (
        .clock(clk), .aclr(aclr), .in_data(d8), .in_sel(s8),
        .in_valid(v8), .in_ready(r8), .out_data(o8),
        .out_err(e8), .out_valid(ov8), .out_ready(1'b1)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // transfers on the main instance, recorded half a cycle before the edge that performs them
    int          in_q[$];
    int          oc_q[$];
    logic [31:0] out_q[$];
    logic        eq[$];

    always @(negedge clk) begin
        if (!aclr && in_valid && in_ready) in_q.push_back(cyc);
        if (!aclr && out_valid && out_ready) begin
            out_q.push_back(out_data);
            eq.push_back(out_err);
            oc_q.push_back(cyc);
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic clear_q();
        in_q.delete();
        oc_q.delete();
        out_q.delete();
        eq.delete();
    endtask

    task automatic send(input logic [5:0] sel);
        int guard;
        guard = 0;
        in_sel   = sel;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("send_accepted", {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input int n);
        int guard;
        guard = 0;
        while (out_q.size() < n && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("out_count", out_q.size(), n);
    endtask

    typedef struct {
        int          which;
        logic [5:0]  sel;
        logic [31:0] exp_d;
        logic        exp_e;
        int          exp_lat;
    } vec_t;

    function automatic logic aux_valid(input int w);
        case (w)
            0:       return ov45;
            1:       return ov2;
            default: return ov8;
        endcase
    endfunction

    task automatic probe(input vec_t v, input int idx);
        int lat;
        @(posedge clk);
        #1;
        case (v.which)
            0:       begin s45 = v.sel;      v45 = 1'b1; end
            1:       begin s2  = v.sel[2:0]; v2  = 1'b1; end
            default: begin s8  = v.sel;      v8  = 1'b1; end
        endcase
        @(posedge clk);
        #1;
        v45 = 1'b0;
        v2  = 1'b0;
        v8  = 1'b0;
        lat = 1;
        while (!aux_valid(v.which) && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check($sformatf("vec%0d_latency", idx), lat, v.exp_lat);
        case (v.which)
            0: begin
                check($sformatf("vec%0d_data", idx), o45, v.exp_d);
                check($sformatf("vec%0d_err", idx), {31'b0, e45}, {31'b0, v.exp_e});
            end
            1: begin
                check($sformatf("vec%0d_data", idx), {24'b0, o2}, v.exp_d);
                check($sformatf("vec%0d_err", idx), {31'b0, e2}, {31'b0, v.exp_e});
            end
            default: begin
                check($sformatf("vec%0d_data", idx), o8, v.exp_d);
                check($sformatf("vec%0d_err", idx), {31'b0, e8}, {31'b0, v.exp_e});
            end
        endcase
    endtask

    initial begin
        vec_t        vecs[12];
        logic [5:0]  b2b_sel[4];
        logic [31:0] held;
        int          g;

        vecs[0]  = '{0, 6'd0,  32'hB000_0000, 1'b0, 3};
        vecs[1]  = '{0, 6'd44, 32'hB000_002C, 1'b0, 3};
        vecs[2]  = '{0, 6'd45, 32'h0000_0000, 1'b1, 3};
        vecs[3]  = '{0, 6'd63, 32'h0000_0000, 1'b1, 3};
        vecs[4]  = '{0, 6'd31, 32'hB000_001F, 1'b0, 3};
        vecs[5]  = '{0, 6'd32, 32'hB000_0020, 1'b0, 3};
        vecs[6]  = '{1, 6'd7,  32'h0000_00C7, 1'b0, 3};
        vecs[7]  = '{1, 6'd0,  32'h0000_00C0, 1'b0, 3};
        vecs[8]  = '{1, 6'd4,  32'h0000_00C4, 1'b0, 3};
        vecs[9]  = '{2, 6'd63, 32'hD000_003F, 1'b0, 2};
        vecs[10] = '{2, 6'd9,  32'hD000_0009, 1'b0, 2};
        vecs[11] = '{2, 6'd0,  32'hD000_0000, 1'b0, 2};
        b2b_sel  = '{6'd5, 6'd60, 6'd31, 6'd32};

        for (int i = 0; i < 64; i++) in_data[i*32 +: 32] = 32'hA000_0000 + i;
        for (int i = 0; i < 45; i++) d45[i*32 +: 32] = 32'hB000_0000 + i;
        for (int i = 0; i < 8; i++)  d2[i*8 +: 8] = 8'hC0 + 8'(i);
        for (int i = 0; i < 64; i++) d8[i*32 +: 32] = 32'hD000_0000 + i;

        aclr = 1'b1;
        in_valid = 1'b0; in_sel = '0; out_ready = 1'b1;
        v45 = 1'b0; s45 = '0; v2 = 1'b0; s2 = '0; v8 = 1'b0; s8 = '0;
        repeat (3) @(posedge clk);
        #1;
        aclr = 1'b0;

        @(negedge clk);
        check("reset_out_valid", {31'b0, out_valid}, 32'd0);
        check("reset_out_data", out_data, 32'd0);
        check("reset_out_err", {31'b0, out_err}, 32'd0);
        check("reset_in_ready", {31'b0, in_ready}, 32'd1);

        // full 64-word stream, back to back
        @(posedge clk);
        #1;
        clear_q();
        for (int i = 0; i < 64; i++) send(6'(i));
        wait_out(64);
        for (int i = 0; i < 64; i++) begin
            check($sformatf("stream_data%0d", i), out_q[i], 32'hA000_0000 + i);
            check($sformatf("stream_err%0d", i), {31'b0, eq[i]}, 32'd0);
        end
        check("stream_latency", oc_q[0] - in_q[0], 32'd3);
        check("stream_out_span", oc_q[63] - oc_q[0], 32'd63);
        check("stream_in_span", in_q[63] - in_q[0], 32'd63);

        // independent carried selects
        @(posedge clk);
        #1;
        clear_q();
        for (int i = 0; i < 4; i++) send(b2b_sel[i]);
        wait_out(4);
        for (int i = 0; i < 4; i++)
            check($sformatf("b2b_data%0d", i), out_q[i], 32'hA000_0000 + 32'(b2b_sel[i]));

        // downstream stall in the middle of a 6-item stream
        @(posedge clk);
        #1;
        clear_q();
        fork
            begin
                for (int i = 0; i < 6; i++) send(6'(10 + i));
            end
            begin
                g = 0;
                @(negedge clk);
                while (!out_valid && g < 50) begin
                    @(negedge clk);
                    g++;
                end
                check("stall_start", {31'b0, out_valid}, 32'd1);
                @(posedge clk);
                #1;
                out_ready = 1'b0;
                @(negedge clk);
                held = out_data;
                check("stall_held_word", held, 32'hA000_000B);
                for (int k = 0; k < 4; k++) begin
                    if (k > 0) @(negedge clk);
                    check($sformatf("stall_in_ready%0d", k), {31'b0, in_ready}, 32'd0);
                    check($sformatf("stall_out_valid%0d", k), {31'b0, out_valid}, 32'd1);
                    check($sformatf("stall_data%0d", k), out_data, held);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        wait_out(6);
        for (int i = 0; i < 6; i++)
            check($sformatf("stall_order%0d", i), out_q[i], 32'hA000_000A + i);

        // reset with two items in flight
        @(posedge clk);
        #1;
        clear_q();
        send(6'd20);
        send(6'd21);
        aclr = 1'b1;
        @(posedge clk);
        #1;
        aclr = 1'b0;
        check("aclr_out_valid", {31'b0, out_valid}, 32'd0);
        check("aclr_out_data", out_data, 32'd0);
        check("aclr_out_err", {31'b0, out_err}, 32'd0);
        repeat (6) @(posedge clk);
        #1;
        check("aclr_discarded", out_q.size(), 32'd0);
        in_q.delete();
        send(6'd22);
        wait_out(1);
        check("aclr_new_data", out_q[0], 32'hA000_0016);
        check("aclr_new_latency", oc_q[0] - in_q[0], 32'd3);

        // other geometries
        for (int i = 0; i < 12; i++) probe(vecs[i], i);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pipe_mux_tree.md
Name: pipe_mux_tree

Overview:
Parametrised, fully pipelined N-to-1 word selector built as a registered radix-R tree. It is the generalised successor of the fixed 64:1 radix-4 selector in the compression first stages. Differences from that selector:
- select bits travel down the pipeline with the data, so back-to-back selects are independent;
- valid/ready flow control, with stall propagation;
- out-of-range select detection.
It feeds quantisation/prediction stages that pick one of many candidate words per cycle.

Parameters:
WIDTH, 32, data word width in bits (>=1)
NUM_IN, 64, number of input words (>=2; need not be a power of RADIX)
RADIX, 4, fan-in of each tree node; must be 2, 4 or 8
SEL_W, $clog2(NUM_IN), select width (derived, not overridden)

Ports:
clock  in  1  rising-edge clock
aclr  in  1  synchronous active-high reset
in_data  in  NUM_IN*WIDTH  packed inputs; word i = in_data[i*WIDTH +: WIDTH]
in_sel  in  SEL_W  index of word to forward
in_valid  in  1  in_data/in_sel valid this cycle
in_ready  out  1  block accepts input this cycle
out_data  out  WIDTH  selected word
out_err  out  1  in_sel was >= NUM_IN for this result
out_valid  out  1  out_data/out_err valid
out_ready  in  1  downstream accepts output

Behaviour:
- Reset, synchronous, active-high:
  - on a clock edge with aclr=1, all pipeline registers clear: valid bits 0, data 0, carried sel 0, err 0;
  - after that edge, out_valid=0, out_data=0, out_err=0;
  - aclr overrides any concurrent transfer; in-flight items are discarded, not flushed.
- Tree geometry:
  - RB = log2(RADIX); LEVELS = ceil(log_RADIX(NUM_IN)), minimum 1;
  - inputs are padded with zero words up to RADIX**LEVELS;
  - level k (k=0 at leaves) selects with carried sel bits [RB*k +: RB]; the top level uses the remaining bits, zero-extended.
- Registering and latency:
  - every level is registered; latency = LEVELS cycles from accepted input to out_valid;
  - 64/4 gives 3 cycles; 45/4 gives 3 cycles; 8/2 gives 3 cycles.
- Select and error carry: each stage carries its unconsumed sel bits, valid and err alongside its data.
- Out-of-range select:
  - err is computed at acceptance as (in_sel >= NUM_IN) and carried to out_err;
  - out_data for an erroneous item is forced to 0; never a padding or aliased word.
- Flow control, global stall:
  - adv = !out_valid | out_ready;
  - in_ready = adv (combinational);
  - when adv=1, all stages shift one level; stage 0 loads in_valid and the input (a bubble if in_valid=0);
  - when adv=0, all stages hold, and out_data/out_valid/out_err stay stable until accepted;
  - the output transfer happens on out_valid & out_ready; the input transfer happens on in_valid & in_ready.
- Throughput: 1 item/cycle sustained when out_ready=1; bubbles are not compressed.
- Simultaneous events:
  - output consumed while a new input is accepted in the same cycle is legal and loses nothing;
  - in_valid during aclr is ignored.
- Ordering: strict in-order; no item is duplicated or dropped except by aclr.

Decomposition:
- Shared package (sz_pkg):
  - tree_levels(num_in, radix) constant function;
  - clog2 helper;
  - RADIX legality check constant, used by an elaboration-time assertion in the top.
- One natural sub-module, mux_tree_stage:
  - one registered level of ceil(n/RADIX) RADIX:1 nodes;
  - carries the sel remainder, valid and err;
  - takes an adv enable and a synchronous clear.
- Top: generate-loop of LEVELS instances plus the err/ready logic.

Test Plan:
- Defaults, word i = 32'hA000_0000+i, out_ready=1, in_sel=0..63 on consecutive cycles → out_data = A000_0000..A000_003F in order, first at cycle 3 after first accept, out_err=0, no gaps.
- NUM_IN=45, in_sel=44 → out_data = word 44. in_sel=45 and in_sel=63 → out_data=0, out_err=1, latency 3.
- Back-to-back selects 5, 60, 31, 32 with out_ready=1 → outputs words 5, 60, 31, 32 exactly. Checks independent carried sel and word 31 vs 32 wiring.
- Hold out_ready=0 for 4 cycles during a 6-item stream → in_ready=0 while out_valid=1; out_data stable; all 6 items arrive once each, in order, after out_ready=1.
- Assert aclr for 1 cycle with 2 items in flight → next cycle out_valid=0, out_data=0; the 2 items never appear; a new item accepted after reset emerges with latency 3.
- RADIX=2, NUM_IN=8, WIDTH=8, in_sel=7 → out_data = word 7 after 3 cycles; RADIX=8, NUM_IN=64 → latency 2.
